// File: rtl/aes_axi_job_sequencer.sv
// Single-beat AXI master that runs one AES-128 encryption job through the AXI-to-APB bridge:
// program plaintext/key/control, wait for the interrupt, clear it, read back the ciphertext.
module aes_axi_job_sequencer #(
    parameter logic [31:0] P_AES_BASE    = 32'h7003_0000,
    parameter int unsigned P_INT_TIMEOUT = 4096
) (
    input  logic         iClk,
    input  logic         iRsn,
    input  logic         iStart,
    input  logic [127:0] iKey,
    input  logic [127:0] iPlain,
    input  logic         iInt,
    output logic         oBusy,
    output logic         oDone,
    output logic         oErr,
    output logic [1:0]   oErrCode,
    output logic [127:0] oCipher,
    output logic [31:0]  oM_AwAddr,
    output logic [1:0]   oM_AwLen,
    output logic         oM_AwValid,
    input  logic         iM_AwReady,
    output logic [31:0]  oM_WData,
    output logic         oM_WLast,
    output logic         oM_WValid,
    input  logic         iM_WReady,
    input  logic [1:0]   iM_BResp,
    input  logic         iM_BValid,
    output logic         oM_BReady,
    output logic [31:0]  oM_ArAddr,
    output logic [1:0]   oM_ArLen,
    output logic         oM_ArValid,
    input  logic         iM_ArReady,
    input  logic [31:0]  iM_RData,
    input  logic [1:0]   iM_RResp,
    input  logic         iM_RLast,
    input  logic         iM_RValid,
    output logic         oM_RReady
);

    localparam int unsigned CNT_W = $clog2(P_INT_TIMEOUT) + 1;

    // Step numbering: 0..11 setup writes, 12 pending read, 13 clear write, 14..17 cipher reads
    localparam logic [4:0] STEP_START = 5'd11;
    localparam logic [4:0] STEP_PEND  = 5'd12;
    localparam logic [4:0] STEP_CLR   = 5'd13;
    localparam logic [4:0] STEP_RD0   = 5'd14;
    localparam logic [4:0] STEP_RD3   = 5'd17;

    typedef enum logic [3:0] {
        ST_IDLE, ST_AW, ST_W, ST_B, ST_WAIT_INT, ST_AR, ST_R, ST_DONE, ST_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         step_q, step_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [127:0]       plain_q, plain_d, key_q, key_d;
    logic [127:0]       stage_q, stage_d, cipher_q, cipher_d;
    logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [31:0]        awaddr_q, awaddr_d, wdata_q, wdata_d, araddr_q, araddr_d;
    logic               awvalid_q, awvalid_d, wvalid_q, wvalid_d, wlast_q, wlast_d;
    logic               bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
    logic [1:0]         word_idx;

    function automatic logic [31:0] addr_of(input logic [4:0] step);
        logic [15:0] off;
        if (step < 5'd4)                          off = {12'h400, step[1:0], 2'b00};
        else if (step < 5'd8)                     off = {12'h200, step[1:0], 2'b00};
        else if (step == 5'd8)                    off = 16'hA000;
        else if (step == 5'd9)                    off = 16'hA008;
        else if (step == 5'd10)                   off = 16'h0004;
        else if (step == STEP_START)              off = 16'h0000;
        else if (step == STEP_PEND || step == STEP_CLR) off = 16'hA004;
        else                                      off = {12'h600, 2'(step - STEP_RD0), 2'b00};
        return P_AES_BASE + {16'h0000, off};
    endfunction

    function automatic logic [31:0] wdata_of(input logic [4:0] step, input logic [127:0] plain,
                                             input logic [127:0] key);
        logic [31:0] d;
        if (step < 5'd4)        d = plain[{step[1:0], 5'b00000} +: 32];
        else if (step < 5'd8)   d = key[{step[1:0], 5'b00000} +: 32];
        else if (step == 5'd10) d = 32'd16;
        else                    d = 32'd1;
        return d;
    endfunction

    assign word_idx = 2'(step_q - STEP_RD0);

    // Next-state and registered-output computation
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        cnt_d      = cnt_q;
        plain_d    = plain_q;
        key_d      = key_q;
        stage_d    = stage_q;
        cipher_d   = cipher_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        awaddr_d   = awaddr_q;
        awvalid_d  = awvalid_q;
        wdata_d    = wdata_q;
        wlast_d    = wlast_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        araddr_d   = araddr_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;

        unique case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    state_d    = ST_AW;
                    step_d     = '0;
                    busy_d     = 1'b1;
                    err_code_d = 2'b00;
                    plain_d    = iPlain;
                    key_d      = iKey;
                    awaddr_d   = addr_of(5'd0);
                    awvalid_d  = 1'b1;
                end
            end
            ST_AW: begin
                if (awvalid_q && iM_AwReady) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b1;
                    wlast_d   = 1'b1;
                    wdata_d   = wdata_of(step_q, plain_q, key_q);
                    state_d   = ST_W;
                end
            end
            ST_W: begin
                if (wvalid_q && iM_WReady) begin
                    wvalid_d = 1'b0;
                    wlast_d  = 1'b0;
                    bready_d = 1'b1;
                    state_d  = ST_B;
                end
            end
            ST_B: begin
                if (bready_q && iM_BValid) begin
                    bready_d = 1'b0;
                    if (iM_BResp != 2'b00) begin
                        state_d    = ST_ERR;
                        err_d      = 1'b1;
                        busy_d     = 1'b0;
                        err_code_d = 2'b01;
                    end else if (step_q == STEP_START) begin
                        state_d = ST_WAIT_INT;
                        step_d  = STEP_PEND;
                        cnt_d   = '0;
                    end else if (step_q == STEP_CLR) begin
                        state_d   = ST_AR;
                        step_d    = STEP_RD0;
                        araddr_d  = addr_of(STEP_RD0);
                        arvalid_d = 1'b1;
                    end else begin
                        state_d   = ST_AW;
                        step_d    = step_q + 5'd1;
                        awaddr_d  = addr_of(step_q + 5'd1);
                        awvalid_d = 1'b1;
                    end
                end
            end
            ST_WAIT_INT: begin
                if (iInt) begin
                    state_d   = ST_AR;
                    araddr_d  = addr_of(STEP_PEND);
                    arvalid_d = 1'b1;
                end else if (cnt_q == CNT_W'(P_INT_TIMEOUT - 1)) begin
                    state_d    = ST_ERR;
                    err_d      = 1'b1;
                    busy_d     = 1'b0;
                    err_code_d = 2'b11;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_AR: begin
                if (arvalid_q && iM_ArReady) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_R;
                end
            end
            ST_R: begin
                if (rready_q && iM_RValid) begin
                    rready_d = 1'b0;
                    if (iM_RResp != 2'b00 || !iM_RLast) begin
                        state_d    = ST_ERR;
                        err_d      = 1'b1;
                        busy_d     = 1'b0;
                        err_code_d = 2'b10;
                    end else if (step_q == STEP_PEND) begin
                        if (iM_RData[0]) begin
                            state_d   = ST_AW;
                            step_d    = STEP_CLR;
                            awaddr_d  = addr_of(STEP_CLR);
                            awvalid_d = 1'b1;
                        end else begin
                            state_d   = ST_AR;
                            step_d    = STEP_RD0;
                            araddr_d  = addr_of(STEP_RD0);
                            arvalid_d = 1'b1;
                        end
                    end else begin
                        // Cipher words are staged so an aborted job leaves oCipher untouched
                        stage_d[{word_idx, 5'b00000} +: 32] = iM_RData;
                        if (step_q == STEP_RD3) begin
                            state_d  = ST_DONE;
                            done_d   = 1'b1;
                            busy_d   = 1'b0;
                            cipher_d = stage_d;
                        end else begin
                            state_d   = ST_AR;
                            step_d    = step_q + 5'd1;
                            araddr_d  = addr_of(step_q + 5'd1);
                            arvalid_d = 1'b1;
                        end
                    end
                end
            end
            ST_DONE, ST_ERR: begin
                state_d = ST_IDLE;
                step_d  = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge iClk) begin
        if (!iRsn) begin
            state_q    <= ST_IDLE;
            step_q     <= '0;
            cnt_q      <= '0;
            plain_q    <= '0;
            key_q      <= '0;
            stage_q    <= '0;
            cipher_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            awaddr_q   <= '0;
            awvalid_q  <= 1'b0;
            wdata_q    <= '0;
            wlast_q    <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            araddr_q   <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            cnt_q      <= cnt_d;
            plain_q    <= plain_d;
            key_q      <= key_d;
            stage_q    <= stage_d;
            cipher_q   <= cipher_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            awaddr_q   <= awaddr_d;
            awvalid_q  <= awvalid_d;
            wdata_q    <= wdata_d;
            wlast_q    <= wlast_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            araddr_q   <= araddr_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
        end
    end

    assign oBusy      = busy_q;
    assign oDone      = done_q;
    assign oErr       = err_q;
    assign oErrCode   = err_code_q;
    assign oCipher    = cipher_q;
    assign oM_AwAddr  = awaddr_q;
    assign oM_AwLen   = 2'b00;
    assign oM_AwValid = awvalid_q;
    assign oM_WData   = wdata_q;
    assign oM_WLast   = wlast_q;
    assign oM_WValid  = wvalid_q;
    assign oM_BReady  = bready_q;
    assign oM_ArAddr  = araddr_q;
    assign oM_ArLen   = 2'b00;
    assign oM_ArValid = arvalid_q;
    assign oM_RReady  = rready_q;

endmodule
